id_ex_stage: RTL

- ID/EX pipeline stage that feeds the 32-bit ALU (ops: 000 add, 001 and, 010 or, 011 xor, 100 srl b>>a, 101 sll b<<a, 110 sub).
- Resolves operand forwarding in ID and detects load-use hazards.
- Registers the selected ALU operands and control bits into EX.
- Drives the ALU's alua, alub and aluop inputs, plus the EX-stage control signals passed down to MEM.

---
 rtl/id_ex_stage.sv | 134 +++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register for a 32-bit ALU. In ID it picks a forwarding
//   source for each operand, detects load-use hazards and selects the ALU
//   operands. It then registers those operands and the control bits into EX.
//
// Ports
//   clk, clrn            rising-edge clock, asynchronous active-low reset
//   id_*                 decoded instruction fields and register-file data
//   ex_alu               combinational ALU result of the instruction in EX
//   mm_*                 MEM-stage write-back controls and data
//   ex_flush             squash the instruction entering EX
//   stall                combinational load-use hazard (freeze PC and IF/ID)
//   alua, alub, aluop    registered ALU inputs
//   ex_valid, ex_wreg,
//   ex_m2reg, ex_wmem,
//   ex_rn, ex_store_data registered EX-stage controls passed down to MEM
// -----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic          id_use_rs,
    input  logic          id_use_rt,
    input  logic [RW-1:0] id_rn,
    input  logic [DW-1:0] id_qa,
    input  logic [DW-1:0] id_qb,
    input  logic [DW-1:0] id_imm,
    input  logic [4:0]    id_sa,
    input  logic [2:0]    id_aluop,
    input  logic          id_shift,
    input  logic          id_aluimm,
    input  logic          id_wreg,
    input  logic          id_m2reg,
    input  logic          id_wmem,
    input  logic [DW-1:0] ex_alu,
    input  logic          mm_wreg,
    input  logic          mm_m2reg,
    input  logic [RW-1:0] mm_rn,
    input  logic [DW-1:0] mm_alu,
    input  logic [DW-1:0] mm_mo,
    input  logic          ex_flush,
    output logic          stall,
    output logic [DW-1:0] alua,
    output logic [DW-1:0] alub,
    output logic [2:0]    aluop,
    output logic          ex_valid,
    output logic          ex_wreg,
    output logic          ex_m2reg,
    output logic          ex_wmem,
    output logic [RW-1:0] ex_rn,
    output logic [DW-1:0] ex_store_data
);

    // A load in EX has no data yet, so it can only be a stall source, not a
    // forward source. Register 0 is never a forward source.
    logic          ex_fwd_ok;
    logic          mm_fwd_ok;
    logic [DW-1:0] mm_data;
    logic [DW-1:0] fa;
    logic [DW-1:0] fb;
    logic [DW-1:0] next_alua;
    logic [DW-1:0] next_alub;
    logic          load_en;

    assign ex_fwd_ok = ex_valid & ex_wreg & ~ex_m2reg & (ex_rn != '0);
    assign mm_fwd_ok = mm_wreg & (mm_rn != '0);
    assign mm_data   = mm_m2reg ? mm_mo : mm_alu;

    always_comb begin
        fa = id_qa;
        if (ex_fwd_ok && (ex_rn == id_rs))
            fa = ex_alu;
        else if (mm_fwd_ok && (mm_rn == id_rs))
            fa = mm_data;
    end

    always_comb begin
        fb = id_qb;
        if (ex_fwd_ok && (ex_rn == id_rt))
            fb = ex_alu;
        else if (mm_fwd_ok && (mm_rn == id_rt))
            fb = mm_data;
    end

    assign stall = id_valid & ex_valid & ex_wreg & ex_m2reg & (ex_rn != '0) &
                   ((id_use_rs & (ex_rn == id_rs)) | (id_use_rt & (ex_rn == id_rt)));

    assign next_alua = id_shift  ? {{(DW-5){1'b0}}, id_sa} : fa;
    assign next_alub = id_aluimm ? id_imm : fb;

    // Flush, stall and an empty ID slot all produce the same all-zero bubble.
    assign load_en = id_valid & ~stall & ~ex_flush;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            alua          <= '0;
            alub          <= '0;
            aluop         <= 3'b000;
            ex_valid      <= 1'b0;
            ex_wreg       <= 1'b0;
            ex_m2reg      <= 1'b0;
            ex_wmem       <= 1'b0;
            ex_rn         <= '0;
            ex_store_data <= '0;
        end else if (load_en) begin
            alua          <= next_alua;
            alub          <= next_alub;
            aluop         <= id_aluop;
            ex_valid      <= 1'b1;
            ex_wreg       <= id_wreg;
            ex_m2reg      <= id_m2reg;
            ex_wmem       <= id_wmem;
            ex_rn         <= id_rn;
            ex_store_data <= fb;
        end else begin
            alua          <= '0;
            alub          <= '0;
            aluop         <= 3'b000;
            ex_valid      <= 1'b0;
            ex_wreg       <= 1'b0;
            ex_m2reg      <= 1'b0;
            ex_wmem       <= 1'b0;
            ex_rn         <= '0;
            ex_store_data <= '0;
        end
    end

endmodule
